// File: rtl/piezo_pkg.sv
// +-----------------------------------------------------------------------------
// | piezo_pkg : shared types and helpers for the piezo alert scheduler
// | Rev 1.0   : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package piezo_pkg;

  localparam int unsigned ALERT_W = 2;

  typedef enum logic [ALERT_W-1:0] {
    ALERT_NONE = 2'd0,
    ALERT_OVR  = 2'd1,
    ALERT_BATT = 2'd2,
    ALERT_MOVE = 2'd3
  } alert_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } sched_state_e;

  // Fixed priority: lower encoding wins, so "higher priority" means numerically smaller.
  function automatic alert_e pick_winner(input logic ovr, input logic batt, input logic move);
    if (ovr)  return ALERT_OVR;
    if (batt) return ALERT_BATT;
    if (move) return ALERT_MOVE;
    return ALERT_NONE;
  endfunction

  function automatic bit dur_ok(input longint unsigned v, input int unsigned w);
    return (v >= 64'd1) && (v <= (64'd1 << w));
  endfunction

  function automatic bit half_ok(input longint unsigned v, input int unsigned w);
    return (v >= 64'd1) && (v < (64'd1 << w));
  endfunction

endpackage

`default_nettype wire

// File: rtl/piezo_tone_gen.sv
// +-----------------------------------------------------------------------------
// | piezo_tone_gen : square-wave generator with registered differential outputs
// | Rev 1.0        : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module piezo_tone_gen
  import piezo_pkg::*;
#(
  parameter int unsigned HP_W = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            restart,
  input  logic [HP_W-1:0] half_per,
  output logic            audio_o,
  output logic            audio_o_n
);

  logic [HP_W-1:0] hcnt_q, hcnt_d;
  logic            audio_q, audio_d;
  logic            audio_n_q;

  always_comb begin
    hcnt_d  = '0;
    audio_d = 1'b0;
    if (en && !restart) begin
      if (hcnt_q == (half_per - HP_W'(1))) begin
        hcnt_d  = '0;
        audio_d = ~audio_q;
      end else begin
        hcnt_d  = hcnt_q + HP_W'(1);
        audio_d = audio_q;
      end
    end
  end

  // Complement is registered from the same next-state value so the pins never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q    <= '0;
      audio_q   <= 1'b0;
      audio_n_q <= 1'b1;
    end else begin
      hcnt_q    <= hcnt_d;
      audio_q   <= audio_d;
      audio_n_q <= ~audio_d;
    end
  end

  assign audio_o   = audio_q;
  assign audio_o_n = audio_n_q;

endmodule

`default_nettype wire

// File: rtl/piezo_alert_sched.sv
// +-----------------------------------------------------------------------------
// | piezo_alert_sched : priority alert arbiter, cadence FSM and piezo tone driver
// |                     Optional feature macro: PIEZO_MUTE_EN (adds mute input)
// | Rev 1.0           : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module piezo_alert_sched
  import piezo_pkg::*;
#(
  parameter int unsigned CNT_W     = 27,
  parameter int unsigned HP_W      = 17,
  parameter int unsigned OVR_HALF  = 8192,
  parameter int unsigned OVR_ON    = 8_388_608,
  parameter int unsigned OVR_OFF   = 8_388_608,
  parameter int unsigned BATT_HALF = 16384,
  parameter int unsigned BATT_ON   = 16_777_216,
  parameter int unsigned BATT_OFF  = 16_777_216,
  parameter int unsigned MOVE_HALF = 65536,
  parameter int unsigned MOVE_ON   = 8_388_608,
  parameter int unsigned MOVE_OFF  = 125_829_120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ovr_spd,
  input  logic       batt_low,
  input  logic       moving,
`ifdef PIEZO_MUTE_EN
  input  logic       mute,
`endif
  output logic       audio_o,
  output logic       audio_o_n,
  output logic [1:0] active,
  output logic       busy
);

  if (!(dur_ok(OVR_ON, CNT_W) && dur_ok(OVR_OFF, CNT_W) &&
        dur_ok(BATT_ON, CNT_W) && dur_ok(BATT_OFF, CNT_W) &&
        dur_ok(MOVE_ON, CNT_W) && dur_ok(MOVE_OFF, CNT_W))) begin : g_bad_dur
    $error("piezo_alert_sched: ON/OFF duration is zero or exceeds CNT_W");
  end

  if (!(half_ok(OVR_HALF, HP_W) && half_ok(BATT_HALF, HP_W) &&
        half_ok(MOVE_HALF, HP_W))) begin : g_bad_half
    $error("piezo_alert_sched: half-period is zero or exceeds HP_W");
  end

  localparam logic [CNT_W-1:0] OVR_ON_LAST   = CNT_W'(OVR_ON - 1);
  localparam logic [CNT_W-1:0] OVR_OFF_LAST  = CNT_W'(OVR_OFF - 1);
  localparam logic [CNT_W-1:0] BATT_ON_LAST  = CNT_W'(BATT_ON - 1);
  localparam logic [CNT_W-1:0] BATT_OFF_LAST = CNT_W'(BATT_OFF - 1);
  localparam logic [CNT_W-1:0] MOVE_ON_LAST  = CNT_W'(MOVE_ON - 1);
  localparam logic [CNT_W-1:0] MOVE_OFF_LAST = CNT_W'(MOVE_OFF - 1);
  localparam logic [HP_W-1:0]  OVR_HP        = HP_W'(OVR_HALF);
  localparam logic [HP_W-1:0]  BATT_HP       = HP_W'(BATT_HALF);
  localparam logic [HP_W-1:0]  MOVE_HP       = HP_W'(MOVE_HALF);

  logic batt_eff, move_eff;

`ifdef PIEZO_MUTE_EN
  assign batt_eff = batt_low & ~mute;
  assign move_eff = moving & ~mute;
`else
  assign batt_eff = batt_low;
  assign move_eff = moving;
`endif

  alert_e winner;
  assign winner = pick_winner(ovr_spd, batt_eff, move_eff);

  sched_state_e     state_q, state_d;
  alert_e           sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic [CNT_W-1:0] on_last, off_last;
  logic [HP_W-1:0]  half_sel;
  logic             tone_restart;

  always_comb begin
    on_last  = '0;
    off_last = '0;
    half_sel = '0;
    case (sel_q)
      ALERT_OVR: begin
        on_last  = OVR_ON_LAST;
        off_last = OVR_OFF_LAST;
        half_sel = OVR_HP;
      end
      ALERT_BATT: begin
        on_last  = BATT_ON_LAST;
        off_last = BATT_OFF_LAST;
        half_sel = BATT_HP;
      end
      ALERT_MOVE: begin
        on_last  = MOVE_ON_LAST;
        off_last = MOVE_OFF_LAST;
        half_sel = MOVE_HP;
      end
      default: ;
    endcase
  end

  // winner != sel covers both preemption (winner higher) and withdrawal (req[sel] low),
  // and takes precedence over cadence expiry.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q + CNT_W'(1);
    tone_restart = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        sel_d = ALERT_NONE;
        if (winner != ALERT_NONE) begin
          state_d      = ON;
          sel_d        = winner;
          tone_restart = 1'b1;
        end
      end
      ON, OFF: begin
        if ((winner != sel_q) || ((state_q == OFF) && (cnt_q == off_last))) begin
          cnt_d = '0;
          if (winner != ALERT_NONE) begin
            state_d      = ON;
            sel_d        = winner;
            tone_restart = 1'b1;
          end else begin
            state_d = IDLE;
            sel_d   = ALERT_NONE;
          end
        end else if ((state_q == ON) && (cnt_q == on_last)) begin
          state_d = OFF;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = ALERT_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= ALERT_NONE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign active = sel_q;
  assign busy   = busy_q;

  piezo_tone_gen #(
    .HP_W (HP_W)
  ) u_tone (
    .clk       (clk),
    .rst       (rst),
    .en        (state_d == ON),
    .restart   (tone_restart),
    .half_per  (half_sel),
    .audio_o   (audio_o),
    .audio_o_n (audio_o_n)
  );

endmodule

`default_nettype wire

// File: tb/tb_piezo_alert_sched.sv
// +-----------------------------------------------------------------------------
// | tb_piezo_alert_sched : directed self-checking bench for piezo_alert_sched
// | Rev 1.0              : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_piezo_alert_sched;

  logic       clk;
  logic       rst;
  logic       ovr_spd;
  logic       batt_low;
  logic       moving;
`ifdef PIEZO_MUTE_EN
  logic       mute;
`endif
  logic       audio_o;
  logic       audio_o_n;
  logic [1:0] active;
  logic       busy;

  int n_cmp;
  int n_bad;

  piezo_alert_sched #(
    .OVR_HALF  (4),
    .OVR_ON    (16),
    .OVR_OFF   (16),
    .BATT_HALF (6),
    .BATT_ON   (24),
    .BATT_OFF  (24),
    .MOVE_HALF (8),
    .MOVE_ON   (16),
    .MOVE_OFF  (48)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ovr_spd   (ovr_spd),
    .batt_low  (batt_low),
    .moving    (moving),
`ifdef PIEZO_MUTE_EN
    .mute      (mute),
`endif
    .audio_o   (audio_o),
    .audio_o_n (audio_o_n),
    .active    (active),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ovr_spd  = 1'b0;
    batt_low = 1'b0;
    moving   = 1'b0;
`ifdef PIEZO_MUTE_EN
    mute     = 1'b0;
`endif
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ovr_spd = 1'b1; batt_low = 1'b1; moving = 1'b1;
`ifdef PIEZO_MUTE_EN
    mute = 1'b0;
`endif
    tick(3);
    n_cmp++; if (audio_o !== 1'b0) begin n_bad++; $display("FAIL rst_audio got %b want 0", audio_o); end
    n_cmp++; if (audio_o_n !== 1'b1) begin n_bad++; $display("FAIL rst_audio_n got %b want 1", audio_o_n); end
    n_cmp++; if (active !== 2'd0) begin n_bad++; $display("FAIL rst_active got %0d want 0", active); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    rst = 1'b0;
    tick(1);
    n_cmp++; if (active !== 2'd1) begin n_bad++; $display("FAIL rst_release_active got %0d want 1", active); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_release_busy got %b want 1", busy); end
  endtask

  task automatic test_move_cadence();
    do_reset();
    moving = 1'b1;
    tick(1);
    for (int k = 0; k <= 80; k++) begin
      logic exp_a;
      exp_a = ((k % 64) >= 8) && ((k % 64) < 16);
      n_cmp++; if (audio_o !== exp_a) begin n_bad++; $display("FAIL move_audio k=%0d got %b want %b", k, audio_o, exp_a); end
      n_cmp++; if (audio_o_n !== ~exp_a) begin n_bad++; $display("FAIL move_audio_n k=%0d got %b want %b", k, audio_o_n, ~exp_a); end
      n_cmp++; if (active !== 2'd3) begin n_bad++; $display("FAIL move_active k=%0d got %0d want 3", k, active); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL move_busy k=%0d got %b want 1", k, busy); end
      tick(1);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    moving = 1'b1;
    tick(1);
    tick(4);
    ovr_spd = 1'b1;
    tick(1);
    n_cmp++; if (active !== 2'd1) begin n_bad++; $display("FAIL pre_active got %0d want 1", active); end
    n_cmp++; if (audio_o !== 1'b0) begin n_bad++; $display("FAIL pre_audio0 got %b want 0", audio_o); end
    for (int j = 1; j <= 4; j++) begin
      tick(1);
      n_cmp++; if (audio_o !== (j == 4)) begin n_bad++; $display("FAIL pre_first_toggle j=%0d got %b want %b", j, audio_o, (j == 4)); end
    end
    tick(4);
    n_cmp++; if (audio_o !== 1'b0) begin n_bad++; $display("FAIL pre_toggle2 got %b want 0", audio_o); end
    tick(8);
    n_cmp++; if (active !== 2'd1 || busy !== 1'b1 || audio_o !== 1'b0) begin
      n_bad++; $display("FAIL pre_off active=%0d busy=%b audio=%b want 1/1/0", active, busy, audio_o);
    end
    tick(16);
    n_cmp++; if (active !== 2'd1 || audio_o !== 1'b0) begin
      n_bad++; $display("FAIL pre_reon active=%0d audio=%b want 1/0", active, audio_o);
    end
    tick(4);
    n_cmp++; if (audio_o !== 1'b1) begin n_bad++; $display("FAIL pre_reon_toggle got %b want 1", audio_o); end
  endtask

  task automatic test_withdraw_batt();
    do_reset();
    batt_low = 1'b1; moving = 1'b1;
    tick(1);
    n_cmp++; if (active !== 2'd2) begin n_bad++; $display("FAIL batt_active got %0d want 2", active); end
    tick(5);
    n_cmp++; if (audio_o !== 1'b0) begin n_bad++; $display("FAIL batt_pre_toggle got %b want 0", audio_o); end
    tick(1);
    n_cmp++; if (audio_o !== 1'b1) begin n_bad++; $display("FAIL batt_toggle got %b want 1", audio_o); end
    tick(6);
    n_cmp++; if (audio_o !== 1'b0) begin n_bad++; $display("FAIL batt_toggle2 got %b want 0", audio_o); end
    tick(12);
    n_cmp++; if (active !== 2'd2 || busy !== 1'b1 || audio_o !== 1'b0) begin
      n_bad++; $display("FAIL batt_off active=%0d busy=%b audio=%b want 2/1/0", active, busy, audio_o);
    end
    tick(6);
    batt_low = 1'b0;
    tick(1);
    n_cmp++; if (active !== 2'd3 || busy !== 1'b1 || audio_o !== 1'b0) begin
      n_bad++; $display("FAIL batt_drop active=%0d busy=%b audio=%b want 3/1/0", active, busy, audio_o);
    end
    tick(7);
    n_cmp++; if (audio_o !== 1'b0) begin n_bad++; $display("FAIL batt_drop_pre got %b want 0", audio_o); end
    tick(1);
    n_cmp++; if (audio_o !== 1'b1) begin n_bad++; $display("FAIL batt_drop_tone got %b want 1 (move tone in ON)", audio_o); end
  endtask

  task automatic test_withdraw_ovr();
    do_reset();
    ovr_spd = 1'b1;
    tick(1);
    tick(7);
    n_cmp++; if (audio_o !== 1'b1) begin n_bad++; $display("FAIL ovr_mid got %b want 1", audio_o); end
    ovr_spd = 1'b0;
    tick(1);
    n_cmp++; if (busy !== 1'b0 || active !== 2'd0) begin
      n_bad++; $display("FAIL ovr_drop busy=%b active=%0d want 0/0", busy, active);
    end
    n_cmp++; if (audio_o !== 1'b0 || audio_o_n !== 1'b1) begin
      n_bad++; $display("FAIL ovr_drop_audio audio=%b audio_n=%b want 0/1", audio_o, audio_o_n);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    ovr_spd = 1'b1;
    tick(1);
    tick(5);
    n_cmp++; if (audio_o !== 1'b1) begin n_bad++; $display("FAIL midrst_pre got %b want 1", audio_o); end
    rst = 1'b1;
    tick(1);
    n_cmp++; if (audio_o !== 1'b0 || audio_o_n !== 1'b1 || active !== 2'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midrst audio=%b n=%b active=%0d busy=%b want 0/1/0/0", audio_o, audio_o_n, active, busy);
    end
    rst = 1'b0;
    tick(1);
    n_cmp++; if (active !== 2'd1) begin n_bad++; $display("FAIL midrst_restart got %0d want 1", active); end
  endtask

`ifdef PIEZO_MUTE_EN
  task automatic test_mute();
    do_reset();
    mute = 1'b1; batt_low = 1'b1;
    tick(3);
    n_cmp++; if (active !== 2'd0 || busy !== 1'b0 || audio_o !== 1'b0) begin
      n_bad++; $display("FAIL mute_silent active=%0d busy=%b audio=%b want 0/0/0", active, busy, audio_o);
    end
    ovr_spd = 1'b1;
    tick(1);
    n_cmp++; if (active !== 2'd1) begin n_bad++; $display("FAIL mute_ovr got %0d want 1", active); end
    tick(4);
    n_cmp++; if (audio_o !== 1'b1) begin n_bad++; $display("FAIL mute_ovr_tone got %b want 1", audio_o); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_move_cadence();
    test_preempt();
    test_withdraw_batt();
    test_withdraw_ovr();
    test_reset_mid_burst();
`ifdef PIEZO_MUTE_EN
    test_mute();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
